// File: rtl/bram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bram_pkg
// Purpose  : Shared BRAM datapath widths, readback FSM states and 7-seg table.
// Revision : 1.0 - initial release
// ============================================================================
package bram_pkg;

    localparam int DATA_W_DEF = 48;
    localparam int ADDR_W_DEF = 10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_LATCH = 3'd3,
        ST_SHOW  = 3'd4,
        ST_DONE  = 3'd5
    } rb_state_t;

    // Active-high segment patterns {g,f,e,d,c,b,a}, indexed by hex digit.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h58, 7'h7C, 7'h77, 7'h67, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage
`default_nettype wire

// File: rtl/bram_readback_if.sv
`default_nettype none
// ============================================================================
// Module   : bram_readback_if
// Purpose  : Read-only BRAM port bundle between the readback FSM and the RAM.
// Revision : 1.0 - initial release
// ============================================================================
interface bram_readback_if #(
    parameter int DATA_W = bram_pkg::DATA_W_DEF,
    parameter int ADDR_W = bram_pkg::ADDR_W_DEF
);
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_we;
    logic [DATA_W-1:0] rd_data;

    modport master (
        output rd_addr,
        output rd_we,
        input  rd_data
    );

    modport slave (
        input  rd_addr,
        input  rd_we,
        output rd_data
    );
endinterface
`default_nettype wire

// File: rtl/hex_to_seg7.sv
`default_nettype none
// ============================================================================
// Module   : hex_to_seg7
// Purpose  : Hex digit to active-low 7-segment decoder.
// Revision : 1.0 - initial release
// ============================================================================
module hex_to_seg7
    import bram_pkg::*;
(
    input  wire logic [3:0] i_nib,
    output logic      [6:0] o_seg
);

    assign o_seg = ~SEG_TABLE[i_nib];

endmodule
`default_nettype wire

// File: rtl/bram_readback.sv
`default_nettype none
// ============================================================================
// Module   : bram_readback
// Purpose  : Walks a BRAM window and shows each word nibble by nibble on one
//            active-low 7-segment display. Optional READBACK_CHECK_EN adds a
//            fill-pattern comparator with a sticky mismatch flag.
// Revision : 1.0 - initial release
// ============================================================================
module bram_readback
    import bram_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int START_ADDR = 0,
    parameter int WORD_COUNT = 4,
    parameter int DWELL      = 25_000_000
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             start,
    bram_readback_if.master       bus,
    output logic [6:0]            seg,
    output logic [3:0]            nib_idx,
    output logic                  busy,
    output logic                  done
`ifdef READBACK_CHECK_EN
    ,
    output logic                  mismatch
`endif
);

    localparam int                NIBS      = DATA_W / 4;
    localparam logic [3:0]        TOP_NIB   = 4'(NIBS - 1);
    localparam int                CNT_W     = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(DWELL - 1);
    localparam logic [ADDR_W-1:0] START_A   = ADDR_W'(START_ADDR);
    localparam logic [ADDR_W:0]   LAST_WORD = (ADDR_W + 1)'(WORD_COUNT - 1);

    rb_state_t         r_state;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [DATA_W-1:0] r_word;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W:0]   r_word_cnt;
    logic [6:0]        r_seg;
    logic [3:0]        r_nib_idx;
    logic              r_busy;
    logic              r_done;

    logic [3:0]        w_dec_nib;
    logic [6:0]        w_seg;

    // One decoder serves both the first nibble (straight off the RAM in LATCH)
    // and the following nibble of the held word during SHOW.
    always_comb begin
        w_dec_nib = r_word[{r_nib_idx - 4'd1, 2'b00} +: 4];
        if (r_state == ST_LATCH) begin
            w_dec_nib = bus.rd_data[DATA_W-1 -: 4];
        end
    end

    hex_to_seg7 u_dec (
        .i_nib (w_dec_nib),
        .o_seg (w_seg)
    );

`ifdef READBACK_CHECK_EN
    logic              r_mismatch;
    logic [DATA_W-1:0] w_fill;

    // Fill-writer image: the word address replicated, zero-extended to DATA_W.
    assign w_fill   = DATA_W'({(DATA_W / ADDR_W){r_rd_addr}});
    assign mismatch = r_mismatch;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_rd_addr  <= START_A;
            r_word     <= '0;
            r_cnt      <= '0;
            r_word_cnt <= '0;
            r_seg      <= SEG_BLANK;
            r_nib_idx  <= 4'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
`ifdef READBACK_CHECK_EN
            r_mismatch <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state    <= ST_REQ;
                        r_rd_addr  <= START_A;
                        r_word_cnt <= '0;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
`ifdef READBACK_CHECK_EN
                        r_mismatch <= 1'b0;
`endif
                    end
                end
                ST_REQ: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_state <= ST_LATCH;
                end
                ST_LATCH: begin
                    r_word    <= bus.rd_data;
                    r_nib_idx <= TOP_NIB;
                    r_cnt     <= '0;
                    r_seg     <= w_seg;
                    r_state   <= ST_SHOW;
`ifdef READBACK_CHECK_EN
                    if (bus.rd_data != w_fill) begin
                        r_mismatch <= 1'b1;
                    end
`endif
                end
                ST_SHOW: begin
                    if (r_cnt == LAST_CNT) begin
                        r_cnt <= '0;
                        if (r_nib_idx != 4'd0) begin
                            r_nib_idx <= r_nib_idx - 4'd1;
                            r_seg     <= w_seg;
                        end else if (r_word_cnt == LAST_WORD) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
`ifdef READBACK_CHECK_EN
                            r_seg   <= r_mismatch ? ~7'h71 : ~7'h3F;
`endif
                        end else begin
                            // Address wraps naturally at the top of the RAM.
                            r_rd_addr  <= r_rd_addr + 1'b1;
                            r_word_cnt <= r_word_cnt + 1'b1;
                            r_state    <= ST_REQ;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.rd_addr = r_rd_addr;
    assign bus.rd_we   = 1'b0;
    assign seg         = r_seg;
    assign nib_idx     = r_nib_idx;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_bram_readback.sv
`default_nettype none
// ============================================================================
// Module   : tb_bram_readback
// Purpose  : Directed bench: single-word, two-word and wrapping runs, plus
//            start-while-busy and mid-run reset, on three DUT configurations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bram_readback;

    localparam logic [47:0] W0 = 48'h0123456789AB;
    localparam logic [47:0] W1 = 48'hFEDCBA987654;

    logic       clk;
    logic       reset;
    logic       start;
    logic [1:0] sel;
    logic [2:0] start_v;

    int n_checks = 0;
    int n_errors = 0;

    logic [47:0] mem_one  [1024];
    logic [47:0] mem_two  [1024];
    logic [47:0] mem_wrap [1024];

    logic [6:0] seg_v   [3];
    logic [3:0] nib_v   [3];
    logic       busy_v  [3];
    logic       done_v  [3];
`ifdef READBACK_CHECK_EN
    logic       mism_v  [3];
`endif

    bram_readback_if #(.DATA_W(48), .ADDR_W(10)) if_one  ();
    bram_readback_if #(.DATA_W(48), .ADDR_W(10)) if_two  ();
    bram_readback_if #(.DATA_W(48), .ADDR_W(10)) if_wrap ();

    assign start_v = start ? (3'b001 << sel) : 3'b000;

    bram_readback #(.DATA_W(48), .ADDR_W(10), .START_ADDR(0), .WORD_COUNT(1), .DWELL(3)) u_one (
        .clk(clk), .reset(reset), .start(start_v[0]), .bus(if_one),
        .seg(seg_v[0]), .nib_idx(nib_v[0]), .busy(busy_v[0]), .done(done_v[0])
`ifdef READBACK_CHECK_EN
        , .mismatch(mism_v[0])
`endif
    );

    bram_readback #(.DATA_W(48), .ADDR_W(10), .START_ADDR(0), .WORD_COUNT(2), .DWELL(3)) u_two (
        .clk(clk), .reset(reset), .start(start_v[1]), .bus(if_two),
        .seg(seg_v[1]), .nib_idx(nib_v[1]), .busy(busy_v[1]), .done(done_v[1])
`ifdef READBACK_CHECK_EN
        , .mismatch(mism_v[1])
`endif
    );

    bram_readback #(.DATA_W(48), .ADDR_W(10), .START_ADDR(1023), .WORD_COUNT(2), .DWELL(3)) u_wrap (
        .clk(clk), .reset(reset), .start(start_v[2]), .bus(if_wrap),
        .seg(seg_v[2]), .nib_idx(nib_v[2]), .busy(busy_v[2]), .done(done_v[2])
`ifdef READBACK_CHECK_EN
        , .mismatch(mism_v[2])
`endif
    );

    // Registered RAM models: data valid one cycle after the address.
    always @(posedge clk) if_one.rd_data  <= mem_one[if_one.rd_addr];
    always @(posedge clk) if_two.rd_data  <= mem_two[if_two.rd_addr];
    always @(posedge clk) if_wrap.rd_data <= mem_wrap[if_wrap.rd_addr];

    logic [6:0] obs_seg;
    logic [3:0] obs_nib;
    logic       obs_busy;
    logic       obs_done;
    logic       obs_we;
    logic [9:0] obs_addr;

    always_comb begin
        obs_seg  = seg_v[0];
        obs_nib  = nib_v[0];
        obs_busy = busy_v[0];
        obs_done = done_v[0];
        obs_we   = if_one.rd_we;
        obs_addr = if_one.rd_addr;
        case (sel)
            2'd1: begin
                obs_seg = seg_v[1]; obs_nib = nib_v[1]; obs_busy = busy_v[1];
                obs_done = done_v[1]; obs_we = if_two.rd_we; obs_addr = if_two.rd_addr;
            end
            2'd2: begin
                obs_seg = seg_v[2]; obs_nib = nib_v[2]; obs_busy = busy_v[2];
                obs_done = done_v[2]; obs_we = if_wrap.rd_we; obs_addr = if_wrap.rd_addr;
            end
            default: ;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] exp_seg(input logic [3:0] n);
        logic [6:0] p;
        case (n)
            4'h0: p = 7'h3F; 4'h1: p = 7'h06; 4'h2: p = 7'h5B; 4'h3: p = 7'h4F;
            4'h4: p = 7'h66; 4'h5: p = 7'h6D; 4'h6: p = 7'h7D; 4'h7: p = 7'h07;
            4'h8: p = 7'h7F; 4'h9: p = 7'h67; 4'hA: p = 7'h77; 4'hB: p = 7'h7C;
            4'hC: p = 7'h58; 4'hD: p = 7'h5E; 4'hE: p = 7'h79; default: p = 7'h71;
        endcase
        return ~p;
    endfunction

    // Images in this bench never match the fill pattern, so the checker
    // variant always ends on "F".
    function automatic logic [6:0] done_seg(input logic [3:0] last_nib);
`ifdef READBACK_CHECK_EN
        return ~7'h71;
`else
        return exp_seg(last_nib);
`endif
    endfunction

    // Entered at the negedge right after the first digit of a word appears.
    task automatic show_word(input logic [47:0] w, input int last_hold);
        int hold;
        for (int n = 11; n >= 0; n--) begin
            hold = (n == 0) ? last_hold : 3;
            for (int c = 0; c < hold; c++) begin
                check_eq($sformatf("seg n%0d c%0d", n, c), obs_seg, exp_seg(w[n*4 +: 4]));
                check_eq($sformatf("nib_idx n%0d c%0d", n, c), obs_nib, n);
                if (c == 0) begin
                    check_eq("busy in run", obs_busy, 1);
                    check_eq("done in run", obs_done, 0);
                    check_eq("rd_we in run", obs_we, 0);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic pulse_start_to_first_digit();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("busy after start", obs_busy, 1);
        check_eq("done after start", obs_done, 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_done(input logic [3:0] last_nib);
        check_eq("done at end", obs_done, 1);
        check_eq("busy at end", obs_busy, 0);
        check_eq("seg at end", obs_seg, done_seg(last_nib));
        check_eq("rd_we at end", obs_we, 0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem_one[i]  = '0;
            mem_two[i]  = '0;
            mem_wrap[i] = '0;
        end
        mem_one[0]     = W0;
        mem_two[0]     = W0;
        mem_two[1]     = W1;
        mem_wrap[1023] = W0;
        mem_wrap[0]    = W1;

        reset = 1'b1;
        start = 1'b1;
        sel   = 2'd0;
        repeat (4) @(negedge clk);

        check_eq("reset seg", obs_seg, 7'h7F);
        check_eq("reset busy", obs_busy, 0);
        check_eq("reset done", obs_done, 0);
        check_eq("reset nib_idx", obs_nib, 0);
        check_eq("reset rd_addr", obs_addr, 0);
        check_eq("reset rd_we", obs_we, 0);
        check_eq("reset wrap rd_addr", if_wrap.rd_addr, 10'd1023);
        check_eq("reset two busy", busy_v[1], 0);
`ifdef READBACK_CHECK_EN
        check_eq("reset mismatch", mism_v[0], 0);
`endif

        reset = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("idle busy", obs_busy, 0);
        check_eq("idle seg", obs_seg, 7'h7F);

        // Single-word run
        sel = 2'd0;
        pulse_start_to_first_digit();
        check_eq("one rd_addr", obs_addr, 0);
        show_word(W0, 3);
        check_done(4'hB);
`ifdef READBACK_CHECK_EN
        check_eq("one mismatch", mism_v[0], 1);
`endif

        // Two-word run: 'B' held 6 cycles while word 1 is fetched
        sel = 2'd1;
        pulse_start_to_first_digit();
        check_eq("two rd_addr w0", obs_addr, 0);
        show_word(W0, 6);
        check_eq("two rd_addr w1", obs_addr, 1);
        show_word(W1, 3);
        check_done(4'h4);
        check_eq("two rd_addr hold", obs_addr, 1);

        // Window crossing the top of the address space
        sel = 2'd2;
        pulse_start_to_first_digit();
        check_eq("wrap rd_addr w0", obs_addr, 10'd1023);
        show_word(W0, 6);
        check_eq("wrap rd_addr w1", obs_addr, 0);
        show_word(W1, 3);
        check_done(4'h4);

        // Start while busy is ignored, then reset mid-SHOW aborts
        sel = 2'd0;
        pulse_start_to_first_digit();
        check_eq("restart seg", obs_seg, exp_seg(4'h0));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("busy start nib", obs_nib, 11);
        check_eq("busy start seg", obs_seg, exp_seg(4'h0));
        repeat (2) @(negedge clk);
        check_eq("busy start nib adv", obs_nib, 10);
        check_eq("busy start seg adv", obs_seg, exp_seg(4'h1));
        reset = 1'b1;
        @(negedge clk);
        check_eq("abort seg", obs_seg, 7'h7F);
        check_eq("abort busy", obs_busy, 0);
        check_eq("abort done", obs_done, 0);
        check_eq("abort nib_idx", obs_nib, 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("post abort done", obs_done, 0);
        check_eq("post abort busy", obs_busy, 0);
        check_eq("post abort seg", obs_seg, 7'h7F);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
